// File: rtl/int_arb.sv
// External interrupt arbiter: synchronises and edge-captures peripheral lines,
// picks one enabled pending source round-robin and runs a claim/complete handshake.
module int_arb #(
  parameter int          NUM_SRC      = 8,
  parameter logic [7:0]  INT_EXT_FLAG = 8'h02
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic [7:0]         int_flag_o
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IW-1:0] PTR_RST = IW'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_ASSERT = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  logic [NUM_SRC-1:0]   r_sync1;
  logic [NUM_SRC-1:0]   r_sync2;
  logic [NUM_SRC-1:0]   r_prev;
  logic [NUM_SRC-1:0]   r_edge;
  logic [NUM_SRC-1:0]   r_enable;
  logic [NUM_SRC-1:0]   r_pending;
  state_t               r_state;
  logic [IW-1:0]        r_grant;
  logic [IW-1:0]        r_ptr;
  logic [7:0]           r_flag;

  logic                 w_rd;
  logic                 w_wr;
  logic [1:0]           w_sel;
  logic [NUM_SRC-1:0]   w_cand;
  logic [2*NUM_SRC-1:0] w_dbl;
  logic [2*NUM_SRC-1:0] w_rot_full;
  logic [NUM_SRC-1:0]   w_rot;
  logic [31:0]          w_shamt;
  logic                 w_hit;
  logic [IW-1:0]        w_off;
  logic [31:0]          w_sum;
  logic [IW-1:0]        w_hit_idx;
  logic [31:0]          w_grant_id;
  logic [NUM_SRC-1:0]   w_grant_oh;
  logic                 w_claim_rd;
  logic                 w_cmp_wr;
  logic [NUM_SRC-1:0]   w_clr;
  logic [NUM_SRC-1:0]   w_en_next;
  logic [NUM_SRC-1:0]   w_pend_next;
  state_t               w_state_next;

  assign w_rd       = req_i & ~we_i;
  assign w_wr       = req_i & we_i;
  assign w_sel      = addr_i[3:2];
  assign w_grant_id = 32'(r_grant) + 32'd1;
  assign w_grant_oh = NUM_SRC'(1'b1) << r_grant;
  assign w_claim_rd = w_rd && (w_sel == 2'd2) && (r_state == ST_ASSERT);
  assign w_cmp_wr   = w_wr && (w_sel == 2'd3) && (r_state == ST_ACTIVE) &&
                      (data_i[4:0] == w_grant_id[4:0]);

  // Round-robin search: rotate candidates so index ptr+1 lands at bit 0.
  assign w_cand     = r_pending & r_enable;
  assign w_dbl      = {w_cand, w_cand};
  assign w_shamt    = 32'(r_ptr) + 32'd1;
  assign w_rot_full = w_dbl >> w_shamt;
  assign w_rot      = w_rot_full[NUM_SRC-1:0];

  // Lowest set bit of the rotated candidate vector.
  always_comb begin
    w_hit = 1'b0;
    w_off = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_hit = 1'b1;
        w_off = IW'(k);
      end else begin
        w_hit = w_hit;
      end
    end
  end

  // Undo the rotation: (ptr + 1 + off) modulo NUM_SRC.
  always_comb begin
    w_sum = 32'(r_ptr) + 32'd1 + 32'(w_off);
    if (w_sum >= 32'(NUM_SRC)) begin
      w_sum = w_sum - 32'(NUM_SRC);
    end else begin
      w_sum = w_sum;
    end
  end

  assign w_hit_idx = w_sum[IW-1:0];

  // Next register values from bus writes, claims and captured edges; a new edge beats a clear.
  always_comb begin
    w_clr     = '0;
    w_en_next = r_enable;
    if (w_wr && (w_sel == 2'd0)) begin
      w_en_next = data_i[NUM_SRC-1:0];
    end else begin
      w_en_next = r_enable;
    end
    if (w_wr && (w_sel == 2'd1)) begin
      w_clr = data_i[NUM_SRC-1:0];
    end else if (w_claim_rd) begin
      w_clr = w_grant_oh;
    end else begin
      w_clr = '0;
    end
    w_pend_next = (r_pending & ~w_clr) | r_edge;
  end

  // Arbitration state machine next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (|w_cand) w_state_next = ST_ARB;
        else         w_state_next = ST_IDLE;
      end
      ST_ARB: begin
        if (w_hit) w_state_next = ST_ASSERT;
        else       w_state_next = ST_IDLE;
      end
      ST_ASSERT: begin
        if (w_claim_rd)
          w_state_next = ST_ACTIVE;
        else if (!w_en_next[r_grant] || !w_pend_next[r_grant])
          w_state_next = ST_IDLE;
        else
          w_state_next = ST_ASSERT;
      end
      ST_ACTIVE: begin
        if (w_cmp_wr) w_state_next = ST_IDLE;
        else          w_state_next = ST_ACTIVE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Input synchroniser and registered rising-edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_edge  <= '0;
    end else begin
      r_sync1 <= irq_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_edge  <= r_sync2 & ~r_prev;
    end
  end

  // Control/status registers, state, grant and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enable  <= '0;
      r_pending <= '0;
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_ptr     <= PTR_RST;
      r_flag    <= 8'h00;
    end else begin
      r_enable  <= w_en_next;
      r_pending <= w_pend_next;
      r_state   <= w_state_next;
      r_flag    <= (w_state_next == ST_ASSERT) ? INT_EXT_FLAG : 8'h00;
      if ((r_state == ST_ARB) && w_hit) begin
        r_grant <= w_hit_idx;
        r_ptr   <= w_hit_idx;
      end else begin
        r_grant <= r_grant;
        r_ptr   <= r_ptr;
      end
    end
  end

  // Read mux; CLAIM only reports an ID while the source is being presented.
  always_comb begin
    data_o = 32'd0;
    case (w_sel)
      2'd0:    data_o = 32'(r_enable);
      2'd1:    data_o = 32'(r_pending);
      2'd2:    data_o = (r_state == ST_ASSERT) ? w_grant_id : 32'd0;
      default: data_o = 32'd0;
    endcase
  end

  assign int_flag_o = r_flag;

endmodule

// File: doc/int_arb.md
# int_arb

Multi-source external interrupt arbiter between peripheral interrupt lines and the core's `int_flag_i` input. It synchronises and edge-captures up to `NUM_SRC` lines into a pending register and picks one enabled pending source by round-robin. It presents that source to the core as the external interrupt flag and runs a software claim/complete handshake over the peripheral bus. The core's interrupt controller sequences mepc/mstatus/mcause entry; this block decides which source is presented and when.

## Interface

- `NUM_SRC`, 8: number of interrupt sources (2..31).
- `INT_EXT_FLAG`, 8'h02: value driven on `int_flag_o` while a source is presented.

- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-high reset.
- `irq_i`  in  NUM_SRC: raw interrupt lines, asynchronous, rising-edge significant.
- `req_i`  in  1: bus access strobe, one cycle per access.
- `we_i`  in  1: 1 = write, 0 = read.
- `addr_i`  in  32: byte address; only `addr_i[3:2]` decoded.
- `data_i`  in  32: write data.
- `data_o`  out  32: read data, combinational from `addr_i`.
- `int_flag_o`  out  8: to core `int_flag_i`; `INT_EXT_FLAG` or 8'h00.

## Operation

- Register map, by `addr_i[3:2]`:
  - 0 ENABLE (RW): bits [NUM_SRC-1:0], other bits read 0.
  - 1 PENDING (RO, write-1-to-clear).
  - 2 CLAIM (RO): read returns granted ID (index+1), or 0 when state is not ASSERT.
  - 3 COMPLETE (WO, reads 0): write ID to finish service.
- Input path: two-flop synchroniser per line, then a rising-edge detect against the previous synchronised value. An edge sets `pending[i]` regardless of enable.
- If an edge sets a bit and a PENDING W1C clears the same bit in the same cycle, the set wins.
- Claim read (`req_i & ~we_i`, addr 2, state ASSERT) clears `pending[grant]` at that clock edge.
- State machine, `state`:
  - IDLE: if any `pending & enable`, go to ARB.
  - ARB: search `pending & enable` starting at `ptr+1` modulo NUM_SRC, wrapping. Register the first hit into `grant` and set `ptr <= grant`, then go to ASSERT. If no candidate remains (cleared meanwhile), return to IDLE.
  - ASSERT: `int_flag_o = INT_EXT_FLAG`.
    - Claim read: go to ACTIVE.
    - `enable[grant]` or `pending[grant]` cleared by software: return to IDLE (withdraw).
  - ACTIVE: COMPLETE write with `data_i[4:0] == grant+1`: go to IDLE. A mismatched ID is ignored and the state stays ACTIVE.
- `int_flag_o` is registered: high exactly in ASSERT, 8'h00 otherwise.
- Edges arriving in any state only set pending bits. They never preempt the current grant.
- Writes to CLAIM, reads of COMPLETE, and accesses with `req_i` low have no side effects.

## Timing

- Reset values:
  - `state` = IDLE, `ENABLE` = 0, `PENDING` = 0, `grant` = 0, `ptr` = NUM_SRC-1 (first search starts at index 0).
  - Synchroniser flops 0, `int_flag_o` = 8'h00.
  - `data_o` follows the register state.
- Reset mid-operation returns all of the above immediately, without waiting for a clock edge.
- Latency from `irq_i` rising (setup-met at edge 0):
  - pending set at edge 3;
  - ARB entered at edge 4;
  - ASSERT entered and `int_flag_o` high after edge 5.
- Claim read in cycle N: `data_o` valid combinationally in cycle N; pending cleared, state ACTIVE and `int_flag_o` low after edge N+1.
- COMPLETE in cycle N: IDLE after edge N+1. If a candidate exists, ARB after N+2 and ASSERT after N+3.
- Minimum spacing between back-to-back grants: 3 cycles after complete.

## Test plan

- Reset: assert `rst` asynchronously mid-ACTIVE.
  - Required: `int_flag_o` = 0, PENDING = 0, ENABLE = 0 before the next clock edge.
  - Required: first grant after reset goes to source 0 when sources 0 and 3 are pending.
- Single source: ENABLE = 0x04, pulse `irq_i[2]`.
  - Required: `int_flag_o` = 8'h02 five edges later.
  - Required: CLAIM read returns 3, PENDING = 0, flag low next cycle.
  - Required: COMPLETE(3) returns to IDLE.
- Round-robin: ENABLE = 0xFF, sources 1, 4, 6 pending, ptr = 4.
  - Required: grant order 6 → 1 → 4 (IDs 7, 2, 5) across three claim/complete pairs.
- Masking/withdraw: source 5 pending with ENABLE = 0, flag stays 0; set ENABLE bit 5, flag asserts.
  - Required: clearing ENABLE in ASSERT drops the flag next cycle, state IDLE, CLAIM reads 0.
- Races:
  - `irq_i[0]` edge and W1C PENDING bit 0 in the same cycle: bit 0 remains 1.
  - COMPLETE(wrong ID): state stays ACTIVE; a correct ID then completes.
- Edge only: hold `irq_i[1]` high across claim/complete.
  - Required: no re-pend; a new rising edge re-pends.
